// File: rtl/spi_pkg.sv
// spi_pkg: types and defaults shared by the SPI master and slave.
package spi_pkg;
    localparam int SPI_DATA_W = 8;
    typedef enum logic {IDLE, SHIFT} spi_s_state_t;
endpackage

// File: rtl/spi_s_if.sv
// spi_s_if: the four SPI wires plus the slave's miso output enable.
interface spi_s_if;
    logic sclk;
    logic ss_n;
    logic mosi;
    logic miso;
    logic miso_oe;
    modport master (output sclk, ss_n, mosi, input miso, miso_oe);
    modport slave (input sclk, ss_n, mosi, output miso, miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall detection on the synced value.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sh;
    logic              prev;
    // Shift the async input in; reset to the line's idle level so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sh   <= {STAGES{init}};
            prev <= init;
        end else begin
            sh   <= {sh[STAGES-2:0], d};
            prev <= sh[STAGES-1];
        end
    end
    assign rise = sh[STAGES-1] & ~prev;
    assign fall = ~sh[STAGES-1] & prev;
endmodule

// File: rtl/spi_s.sv
// spi_s: oversampling SPI slave supporting all four cpol/cpha modes.
module spi_s
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    spi_s_if.slave            spi,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              ready
);
    localparam int CNT_W = $clog2(DATA_W);
    spi_s_state_t      state, state_d;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic [CNT_W-1:0]  bit_cnt;
    logic [SYNC_STAGES-1:0] mosi_sh;
    logic mosi_s, skip;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic lead, trail, sample, shift;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst(rst), .init(cpol), .d(spi.sclk), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
        .clk(clk), .rst(rst), .init(1'b1), .d(spi.ss_n), .rise(ss_rise), .fall(ss_fall)
    );

    // mosi needs the same latency as sclk so data and its sampling edge stay aligned.
    always_ff @(posedge clk) begin
        if (!rst) mosi_sh <= '0;
        else      mosi_sh <= {mosi_sh[SYNC_STAGES-2:0], spi.mosi};
    end

    assign mosi_s   = mosi_sh[SYNC_STAGES-1];
    assign lead     = cpol ? sclk_fall : sclk_rise;
    assign trail    = cpol ? sclk_rise : sclk_fall;
    assign sample   = cpha ? trail : lead;
    assign shift    = cpha ? lead : trail;
    assign spi.miso = tx_sh[DATA_W-1];

    // Frame control: a synced ss_n fall opens a frame, a synced rise closes it.
    always_comb begin
        state_d = state;
        state_d = (state == IDLE && ss_fall) ? SHIFT : (state == SHIFT && ss_rise) ? IDLE : state;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Datapath: skip swallows the first shift edge after a load so the loaded MSB stays on miso.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_sh       <= '0;
            rx_sh       <= '0;
            bit_cnt     <= '0;
            skip        <= 1'b0;
            dout        <= '0;
            done        <= 1'b0;
            ready       <= 1'b1;
            spi.miso_oe <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (ss_fall) begin
                    tx_sh       <= din;
                    bit_cnt     <= '0;
                    skip        <= cpha;
                    ready       <= 1'b0;
                    spi.miso_oe <= 1'b1;
                end
            end else begin
                if (sample) begin
                    rx_sh <= {rx_sh[DATA_W-2:0], mosi_s};
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        dout    <= {rx_sh[DATA_W-2:0], mosi_s};
                        done    <= 1'b1;
                        bit_cnt <= '0;
                        tx_sh   <= din;
                        skip    <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end else if (shift) begin
                    if (skip) skip  <= 1'b0;
                    else      tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                end
                if (ss_rise) begin
                    ready       <= 1'b1;
                    spi.miso_oe <= 1'b0;
                    bit_cnt     <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_s.sv
// tb_spi_s: drives the slave as an SPI master and checks it against a word-level model.
module tb_spi_s;
    localparam int SYNC = 2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpol = 1'b0, cpha = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic done, ready;
    spi_s_if bus();

    spi_s #(.DATA_W(8), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .spi(bus), .cpol(cpol), .cpha(cpha),
        .din(din), .dout(dout), .done(done), .ready(ready)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int half_n = 10;
    int since_edge = 0, done_lat = -1, wide = 0;
    logic prev_done = 1'b0;
    logic [7:0] done_q[$];
    logic [7:0] exp_dout = 8'h00;

    // One clk step; records every done pulse, its dout, and how long after the last pin edge it came.
    task automatic tick();
        @(posedge clk);
        #1;
        since_edge++;
        if (done === 1'b1) begin
            done_q.push_back(dout);
            done_lat = since_edge;
            if (prev_done) wide++;
        end
        prev_done = (done === 1'b1);
    endtask

    task automatic half();
        repeat (half_n) tick();
    endtask

    task automatic edge_sclk();
        bus.sclk = ~bus.sclk;
        since_edge = 0;
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        cpol = pol;
        cpha = pha;
        bus.sclk = pol;
        half();
    endtask

    // Master side of nbits bit-times, MSB first; nxt is put on din once the current word is loaded.
    task automatic xfer(input int nbits, input logic [7:0] mo, input logic [7:0] nxt, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                bus.mosi = mo[i];
                half();
                if (i == 7) din = nxt;
                mi[i] = bus.miso;
                edge_sclk();
                half();
                edge_sclk();
            end else begin
                edge_sclk();
                bus.mosi = mo[i];
                half();
                if (i == 7) din = nxt;
                mi[i] = bus.miso;
                edge_sclk();
                half();
            end
        end
        if (!cpha) half();
    endtask

    // Whole ss_n frame of nw words; model: word k returns the din present at its load, dout = mosi word.
    task automatic run_frame(input string tag, input logic [7:0] d0, input int nw,
                             input logic [7:0] mo_a [4], input logic [7:0] nx_a [4]);
        logic [7:0] mi, exp_tx;
        int n0;
        din = d0;
        exp_tx = d0;
        n0 = done_q.size();
        bus.ss_n = 1'b0;
        since_edge = 0;
        half();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL %s ready_in_frame got %b want 0", tag, ready); end
        checks++; if (bus.miso_oe !== 1'b1) begin errors++; $display("FAIL %s miso_oe_in_frame got %b want 1", tag, bus.miso_oe); end
        for (int w = 0; w < nw; w++) begin
            done_lat = -1;
            xfer(8, mo_a[w], nx_a[w], mi);
            exp_dout = mo_a[w];
            checks++; if (mi !== exp_tx) begin errors++; $display("FAIL %s miso_word%0d got %h want %h", tag, w, mi, exp_tx); end
            checks++; if (done_q.size() != n0 + w + 1) begin errors++; $display("FAIL %s done_count%0d got %0d want %0d", tag, w, done_q.size() - n0, w + 1); end
            else begin
                checks++; if (done_q[$] !== exp_dout) begin errors++; $display("FAIL %s dout_word%0d got %h want %h", tag, w, done_q[$], exp_dout); end
            end
            checks++; if (done_lat != SYNC + 1) begin errors++; $display("FAIL %s done_latency%0d got %0d want %0d", tag, w, done_lat, SYNC + 1); end
            exp_tx = nx_a[w];
        end
        bus.ss_n = 1'b1;
        half();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL %s ready_after got %b want 1", tag, ready); end
        checks++; if (bus.miso_oe !== 1'b0) begin errors++; $display("FAIL %s miso_oe_after got %b want 0", tag, bus.miso_oe); end
        checks++; if (dout !== exp_dout) begin errors++; $display("FAIL %s dout_hold got %h want %h", tag, dout, exp_dout); end
        checks++; if (wide != 0) begin errors++; $display("FAIL %s done_width wide_pulses %0d want 0", tag, wide); end
    endtask

    task automatic check_reset_state(input string tag);
        checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL %s miso got %b want 0", tag, bus.miso); end
        checks++; if (bus.miso_oe !== 1'b0) begin errors++; $display("FAIL %s miso_oe got %b want 0", tag, bus.miso_oe); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL %s dout got %h want 00", tag, dout); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done got %b want 0", tag, done); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL %s ready got %b want 1", tag, ready); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (4) tick();
        check_reset_state("reset");
        rst = 1'b1;
        exp_dout = 8'h00;
        half();
    endtask

    task automatic test_modes();
        logic [7:0] mo [4], nx [4];
        mo = '{8'h3C, 8'h00, 8'h00, 8'h00};
        nx = '{8'h00, 8'h00, 8'h00, 8'h00};
        half_n = 50;
        set_mode(1'b0, 1'b0);
        run_frame("mode0", 8'hA5, 1, mo, nx);
        half_n = 10;
        mo[0] = 8'h7E;
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            run_frame($sformatf("mode%0d", m), 8'h81, 1, mo, nx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mo [4], nx [4];
        mo = '{8'($urandom), 8'($urandom), 8'h00, 8'h00};
        nx = '{8'h55, 8'h00, 8'h00, 8'h00};
        set_mode(1'b0, 1'b0);
        run_frame("b2b", 8'hA5, 2, mo, nx);
    endtask

    task automatic test_abort();
        logic [7:0] mo [4], nx [4], mi;
        int n0;
        set_mode(1'b0, 1'b0);
        n0 = done_q.size();
        din = 8'h5A;
        bus.ss_n = 1'b0;
        half();
        xfer(5, 8'($urandom), 8'h5A, mi);
        bus.ss_n = 1'b1;
        half();
        checks++; if (done_q.size() != n0) begin errors++; $display("FAIL abort done_count got %0d want 0", done_q.size() - n0); end
        checks++; if (dout !== exp_dout) begin errors++; $display("FAIL abort dout got %h want %h", dout, exp_dout); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort ready got %b want 1", ready); end
        checks++; if (bus.miso_oe !== 1'b0) begin errors++; $display("FAIL abort miso_oe got %b want 0", bus.miso_oe); end
        mo = '{8'hC3, 8'h00, 8'h00, 8'h00};
        nx = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("after_abort", 8'($urandom), 1, mo, nx);
    endtask

    task automatic test_reset_mid();
        logic [7:0] mo [4], nx [4], mi;
        int n0;
        set_mode(1'b0, 1'b1);
        n0 = done_q.size();
        din = 8'h3F;
        bus.ss_n = 1'b0;
        half();
        xfer(3, 8'($urandom), 8'h3F, mi);
        rst = 1'b0;
        tick();
        check_reset_state("reset_mid");
        rst = 1'b1;
        bus.ss_n = 1'b1;
        exp_dout = 8'h00;
        half();
        checks++; if (done_q.size() != n0) begin errors++; $display("FAIL reset_mid done_count got %0d want 0", done_q.size() - n0); end
        mo = '{8'h96, 8'h00, 8'h00, 8'h00};
        nx = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("after_reset", 8'($urandom), 1, mo, nx);
    endtask

    task automatic test_idle_sclk();
        int n0;
        n0 = done_q.size();
        set_mode(1'b1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            edge_sclk();
            bus.mosi = 1'($urandom);
            repeat (4) tick();
        end
        checks++; if (done_q.size() != n0) begin errors++; $display("FAIL idle_sclk done_count got %0d want 0", done_q.size() - n0); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_sclk ready got %b want 1", ready); end
        checks++; if (bus.miso_oe !== 1'b0) begin errors++; $display("FAIL idle_sclk miso_oe got %b want 0", bus.miso_oe); end
        checks++; if (dout !== exp_dout) begin errors++; $display("FAIL idle_sclk dout got %h want %h", dout, exp_dout); end
    endtask

    task automatic test_random();
        logic [7:0] mo [4], nx [4];
        int m;
        for (int f = 0; f < 10; f++) begin
            m = $urandom_range(0, 3);
            for (int k = 0; k < 4; k++) begin
                mo[k] = 8'($urandom);
                nx[k] = 8'($urandom);
            end
            set_mode(m[1], m[0]);
            run_frame($sformatf("rand%0d_m%0d", f, m), 8'($urandom), $urandom_range(1, 3), mo, nx);
        end
    endtask

    initial begin
        bus.sclk = 1'b0;
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        test_reset();
        test_modes();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_idle_sclk();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
